// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                loader: FSM state encoding, default memory geometry and
//                the number of byte lanes per instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_ADDR_W = 6;
    localparam int BYTE_LANES     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_packer
//  Description : Assembles little-endian 32-bit words from a byte stream and
//                keeps a running XOR of every byte taken.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - zero lane counter, word and XOR accumulator
//                take          - a payload byte is being consumed this cycle
//                data[7:0]     - the payload byte
//                word_next     - word including the byte being taken now;
//                                complete when word_ready is high
//                word_ready    - the byte taken now completes a word
//                xor_acc[7:0]  - XOR of all bytes taken since clear
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        word_ready,
    output logic [7:0]  xor_acc
);

    localparam int CNT_W = $clog2(BYTE_LANES);

    logic [31:0]      word;
    logic [CNT_W-1:0] byte_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word     <= 32'd0;
            byte_cnt <= '0;
            xor_acc  <= 8'd0;
        end else if (take) begin
            word[8*byte_cnt +: 8] <= data;
            xor_acc               <= xor_acc ^ data;
            // Counter width matches the lane count, so it wraps to 0 after lane 3.
            byte_cnt              <= byte_cnt + 1'b1;
        end
    end

    // The FSM registers the word on the same edge that accepts its last byte,
    // so it needs the word with the incoming byte already merged in.
    always_comb begin
        word_next                  = word;
        word_next[8*byte_cnt +: 8] = data;
    end

    assign word_ready = take && (byte_cnt == CNT_W'(BYTE_LANES - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a program image into instruction memory from a byte
//                stream: header N, 4*N payload bytes (LSB first per word),
//                then an XOR checksum over the payload. Words are written
//                sequentially from address 0; the core is held in reset
//                until a verified image is in place.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start              - begin a load (IDLE/DONE/ERR only)
//                in_valid, in_data  - byte stream input
//                in_ready           - loader accepts a byte
//                mem_we/addr/wdata  - instruction-memory write port
//                cpu_hold           - hold core in reset during/after bad load
//                done, error        - load status levels
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // One extra bit so a full-depth word count (N == DEPTH) is representable.
    localparam int NW = ADDR_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] word_idx;
    logic [NW-1:0]     n_words;

    logic              accept;
    logic              pk_clear;
    logic              pk_take;
    logic [31:0]       word_next;
    logic              word_ready;
    logic [7:0]        xor_acc;
    logic              bad_len;
    logic              last_word;

    assign accept    = in_valid && in_ready;
    assign pk_clear  = (state == ST_LEN)  && accept;
    assign pk_take   = (state == ST_DATA) && accept;
    assign bad_len   = (in_data == 8'd0) || (int'(in_data) > DEPTH);
    assign last_word = ({1'b0, word_idx} == (n_words - 1'b1));

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .take       (pk_take),
        .data       (in_data),
        .word_next  (word_next),
        .word_ready (word_ready),
        .xor_acc    (xor_acc)
    );

    // All outputs are registered and updated on the transition into the
    // state that owns them, so they are valid for the whole state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            n_words   <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_LEN;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (bad_len) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end else begin
                            state    <= ST_DATA;
                            n_words  <= NW'(in_data);
                            word_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_ready) begin
                        state     <= ST_WRITE;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx;
                        mem_wdata <= word_next;
                    end
                end
                ST_WRITE: begin
                    in_ready <= 1'b1;
                    if (last_word) begin
                        state <= ST_CSUM;
                    end else begin
                        state    <= ST_DATA;
                        word_idx <= word_idx + 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == xor_acc) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected memory writes
//                are queued as the stream is driven and popped by a write
//                monitor; status outputs are checked after each load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] img[0:DEPTH-1];
    int          checks   = 0;
    int          errors   = 0;
    int          wr_count = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest queued write,
    // and the loader must not be accepting bytes during the write cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_t e;
            wr_count++;
            chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
            chk("write_expected", {63'd0, (sb.size() != 0)}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", {58'd0, mem_addr}, {58'd0, e.addr});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
            end
        end
    end

    // Present a byte (optionally after random idle cycles) and return at the
    // negedge following the edge on which it was transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = int'($urandom_range(0, 2));
            repeat (n) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input int n, input bit bad, input bit gaps);
        logic [7:0] x;
        logic [7:0] b;
        int         base;
        x    = 8'd0;
        base = wr_count;
        pulse_start();
        send_byte(8'(n), gaps);
        for (int w = 0; w < n; w++) begin
            sb.push_back({ADDR_W'(w), img[w]});
            for (int k = 0; k < 4; k++) begin
                b = img[w][8*k +: 8];
                x = x ^ b;
                send_byte(b, gaps);
            end
        end
        send_byte(bad ? (x ^ 8'h66) : x, gaps);
        in_valid = 1'b0;
        chk("write_count", 64'(wr_count - base), 64'(n));
        chk("queue_drained", 64'(sb.size()), 64'd0);
        if (bad) begin
            chk("bad_csum_status", {61'd0, done, error, cpu_hold}, {61'd0, 3'b011});
        end else begin
            chk("good_status", {61'd0, done, error, cpu_hold}, {61'd0, 3'b100});
        end
    endtask

    task automatic bad_header(input logic [7:0] h);
        int base;
        base = wr_count;
        pulse_start();
        send_byte(h, 1'b0);
        in_valid = 1'b0;
        chk("hdr_err_status", {60'd0, done, error, cpu_hold, in_ready}, {60'd0, 4'b0110});
        repeat (3) @(negedge clk);
        chk("hdr_no_write", 64'(wr_count - base), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {21'd0, in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word back-to-back load with correct checksum.
        img[0] = 32'h03200093;
        img[1] = 32'h00400113;
        run_load(2, 1'b0, 1'b0);

        // Same image, wrong checksum: words still written, then error.
        run_load(2, 1'b1, 1'b0);

        // Illegal headers, then recovery with a one-word load.
        bad_header(8'h00);
        bad_header(8'h41);
        img[0] = 32'hDEADBEEF;
        run_load(1, 1'b0, 1'b0);

        // Full-depth load of random data.
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load(DEPTH, 1'b0, 1'b0);

        // Three-word load with in_valid gaps.
        img[0] = 32'h11223344;
        img[1] = 32'hA5A55A5A;
        img[2] = 32'h00FF00FF;
        run_load(3, 1'b0, 1'b1);

        // Reset after the second payload byte of a load.
        pulse_start();
        send_byte(8'd1, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midload_reset_outputs", {21'd0, in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        img[0] = 32'hCAFEF00D;
        run_load(1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
